key_expander_128: RTL and testbench
===================================

Name: key_expander_128

Overview:
- Iterative AES-128 key schedule for the decryptor datapath.
- Expands a 128-bit cipher key into 11 round keys (rk0..rk10), one round per clock, and holds them in an internal bank.
- The decryptor reads the bank in reverse order (rk10 first) through a registered random-access port. These round keys feed add_round_key, and the stage's SubWord uses the existing sbox cells.

Parameters:
- NUM_ROUNDS, 10, number of expansion rounds; legal values 1..10 (Rcon table holds 10 entries); 10 for AES-128.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to expand key_in; sampled on a rising edge only while the FSM is IDLE.
- key_in  input  128  cipher key, bit-indexed [0:127]; byte 0 = bits [0:7]; word w0 = bits [0:31].
- busy  output  1  high while expansion is in progress.
- done  output  1  one-cycle pulse when rk10 has been written.
- keys_valid  output  1  high while the bank holds a complete, consistent schedule.
- rd_round  input  4  round-key index to read, 0..NUM_ROUNDS.
- rd_key  output  128  registered round key for rd_round, bit-indexed [0:127].

Behaviour:
- Reset (async, reset=1):
  - FSM goes to IDLE; round counter = 0.
  - busy=0, done=0, keys_valid=0, rd_key=128'h0.
  - Bank contents are not cleared; they are unreadable as valid until keys_valid=1.
- FSM states: IDLE and EXPAND.
- IDLE:
  - On an edge with start=1 (edge E0): write rk[0]=key_in, load working word regs w0..w3 from key_in.
  - At E0 also set rnd=1, busy=1, keys_valid=0, and go to EXPAND.
  - start=0: stay in IDLE.
- EXPAND, one edge per round (edges E1..E_N, N=NUM_ROUNDS):
  - t = SubWord(RotWord(w3)) XOR {Rcon[rnd],8'h00,8'h00,8'h00}.
  - RotWord left-rotates by one byte; SubWord uses 4 sbox instances.
  - w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
  - Write rk[rnd]={w0',w1',w2',w3'} and update the working regs; rnd increments.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex).
- Completion:
  - At E_N: FSM returns to IDLE, busy=0, keys_valid=1, done=1.
  - done is high for exactly the cycle after E_N and clears at E_N+1.
  - Total latency: N+1 edges from the sampled start to done.
- start handling:
  - start while busy=1 is ignored; no restart and no queueing.
  - start in IDLE with keys_valid=1 re-expands: keys_valid drops at E0, and the bank is overwritten.
  - start held high continuously re-triggers on the first IDLE edge after done; the bench must drop it.
- Read port:
  - rd_key is registered with 1-cycle latency: rd_key at edge k+1 reflects rd_round at edge k.
  - rd_round > NUM_ROUNDS returns 128'h0.
  - Reads are legal at any time, but data is guaranteed only while keys_valid=1.
  - Read and write of the same index on the same edge returns the old contents.
- Mid-operation reset: aborts immediately to the reset values; the next start performs a full expansion.
- Datapath: purely XOR/sbox; no carries. Widths are exact at 32 bits per word and 128 bits per key.

Test Plan:
- Reset behaviour: assert reset asynchronously mid-cycle -> busy/done/keys_valid/rd_key all 0 immediately, without waiting for a clock edge.
- FIPS-197 A.1: pulse start with key_in=2b7e151628aed2a6abf7158809cf4f3c.
  - busy high for 10 cycles, then done pulse and keys_valid=1.
  - rd_round=0 -> key_in; rd_round=1 -> a0fafe1788542cb123a339392a6c7605; rd_round=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6.
- Zero key: key_in=0.
  - rd_round=1 -> 62636363626363636263636362636363.
  - rd_round=10 -> b4ef5bcb3e92e21123e951cf6f8f188e.
- Ignored start and out-of-range read:
  - Pulse start again at E4 with a different key -> ignored; rk10 still equals the A.1 value.
  - rd_round=11 and rd_round=15 -> 0.
- Re-expansion and abort:
  - After a completed A.1 schedule, start with the zero key -> keys_valid=0 during busy; final bank holds the zero-key schedule.
  - Assert reset at E5, then restart with the A.1 key -> correct rk10 and a single done pulse.
- Reverse-order read: step rd_round 10 down to 0 on consecutive edges -> rd_key presents each key one cycle later, with no bubbles.

Source files
------------

// File: rtl/key_expander_128.sv
// key_expander_128 -- iterative AES-128 key schedule feeding the decryptor.
//
// One expansion round per clock after a sampled start. All round keys
// rk0..rkN are held in an internal bank and read back (typically rk10 first)
// through a registered random-access port.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   start      begin expansion of key_in (sampled only in IDLE)
//   key_in     cipher key, [0:127], word w0 = bits [0:31]
//   busy       expansion in progress
//   done       one-cycle pulse after rkN has been written
//   keys_valid bank holds a complete schedule
//   rd_round   round-key index to read
//   rd_key     registered round key (0 for out-of-range index)

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    // Forward AES S-box, entry 0 in the leftmost byte.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign y = SBOX[{a, 3'b000} +: 8];
endmodule

module key_expander_128 #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    input  logic [3:0]   rd_round,
    output logic [0:127] rd_key
);
    typedef enum logic {IDLE, EXPAND} state_t;

    state_t       state, state_nxt;
    logic [3:0]   rnd;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] bank [0:NUM_ROUNDS];
    logic         load, step, last;

    // SubWord(RotWord(w3)) through four sbox cells.
    logic [31:0] rot, sub, t, n0, n1, n2, n3;
    assign rot = {w3[23:0], w3[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (.a(rot[8*i +: 8]), .y(sub[8*i +: 8]));
    end

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    endfunction

    assign t  = sub ^ {rcon(rnd), 24'h000000};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;

    assign busy = (state == EXPAND);

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = EXPAND;
                end
            end
            EXPAND: begin
                step = 1'b1;
                if (rnd == 4'(NUM_ROUNDS)) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            rnd        <= 4'd0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            w0         <= 32'h0;
            w1         <= 32'h0;
            w2         <= 32'h0;
            w3         <= 32'h0;
        end else begin
            state <= state_nxt;
            done  <= last;
            if (load) begin
                {w0, w1, w2, w3} <= key_in;
                rnd              <= 4'd1;
                keys_valid       <= 1'b0;
            end else if (step) begin
                {w0, w1, w2, w3} <= {n0, n1, n2, n3};
                rnd              <= rnd + 4'd1;
                if (last)
                    keys_valid <= 1'b1;
            end
        end
    end

    // Bank is never cleared; keys_valid gates its meaning.
    always_ff @(posedge clk) begin
        if (load)
            bank[0] <= key_in;
        else if (step)
            bank[rnd] <= {n0, n1, n2, n3};
    end

    // Registered read: same-edge write to the same index returns old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rd_key <= 128'h0;
        else if (rd_round <= 4'(NUM_ROUNDS))
            rd_key <= bank[rd_round];
        else
            rd_key <= 128'h0;
    end
endmodule

// File: tb/tb_key_expander_128.sv
module tb_key_expander_128;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [0:127] key_in = '0;
    logic         busy, done, keys_valid;
    logic [3:0]   rd_round = 4'd0;
    logic [0:127] rd_key;

    int checks = 0;
    int errors = 0;

    logic         rd_en = 1'b0;
    logic         rd_vld_q;
    logic [127:0] exp_q[$];

    localparam logic [127:0] KA = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KB = 128'h000102030405060708090a0b0c0d0e0f;
    logic [127:0] rka [0:10];

    key_expander_128 #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .reset(reset), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .keys_valid(keys_valid),
        .rd_round(rd_round), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Read-side monitor: one pop per read the DUT presents.
    always @(posedge clk or posedge reset)
        if (reset) rd_vld_q <= 1'b0;
        else       rd_vld_q <= rd_en;

    always @(negedge clk) begin
        if (rd_vld_q) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected got=%h want=none", rd_key);
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (rd_key !== e) begin
                    errors++;
                    $display("FAIL rd_key got=%h want=%h", rd_key, e);
                end
            end
        end
    end

    task automatic rd(input logic [3:0] idx, input logic [127:0] want);
        @(posedge clk); #1;
        rd_round = idx;
        rd_en    = 1'b1;
        exp_q.push_back(want);
    endtask

    task automatic rd_end();
        @(posedge clk); #1;
        rd_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic start_pulse(input logic [127:0] k);
        @(posedge clk); #1;
        start  = 1'b1;
        key_in = k;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // Observes the 14 negedges following E0; busy must span 10 of them.
    task automatic watch(input string tag);
        int nb, nd, kv_bad;
        nb = 0; nd = 0; kv_bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (busy) begin
                nb++;
                if (keys_valid) kv_bad++;
            end
            if (done) nd++;
        end
        chk({tag, "_busy_cycles"}, 128'(nb), 128'd10);
        chk({tag, "_done_pulses"}, 128'(nd), 128'd1);
        chk({tag, "_kv_during_busy"}, 128'(kv_bad), 128'd0);
        chk({tag, "_kv_after"}, {127'h0, keys_valid}, 128'd1);
    endtask

    initial begin
        rka[0]  = KA;
        rka[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        rka[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        rka[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rka[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        rka[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rka[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rka[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rka[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        rka[9]  = 128'hac7766f319fadc2128d12941575c006e;
        rka[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        #12;
        chk("rst_busy", {127'h0, busy}, 128'd0);
        chk("rst_done", {127'h0, done}, 128'd0);
        chk("rst_kv", {127'h0, keys_valid}, 128'd0);
        chk("rst_rd_key", rd_key, 128'h0);
        @(negedge clk); reset = 1'b0;

        // FIPS-197 A.1
        start_pulse(KA);
        watch("a1");
        rd(4'd0, KA);
        rd(4'd1, rka[1]);
        rd(4'd10, rka[10]);
        rd_end();

        // Reverse read, back to back
        for (int i = 10; i >= 0; i--) rd(4'(i), rka[i]);
        rd_end();

        // Out-of-range reads
        rd(4'd11, 128'h0);
        rd(4'd15, 128'h0);
        rd(4'd10, rka[10]);
        rd_end();

        // Async reset mid-cycle with rd_key holding rk10
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chk("async_rst_busy", {127'h0, busy}, 128'd0);
        chk("async_rst_done", {127'h0, done}, 128'd0);
        chk("async_rst_kv", {127'h0, keys_valid}, 128'd0);
        chk("async_rst_rd_key", rd_key, 128'h0);
        @(negedge clk); reset = 1'b0;

        // Start at E4 with another key is ignored
        start_pulse(KA);
        fork
            watch("ign");
            begin
                repeat (3) @(posedge clk);
                #1; start = 1'b1; key_in = KB;
                @(posedge clk); #1; start = 1'b0;
            end
        join
        rd(4'd10, rka[10]);
        rd(4'd1, rka[1]);
        rd_end();

        // Re-expansion with the zero key over a valid A.1 schedule
        start_pulse(128'h0);
        watch("zero");
        rd(4'd0, 128'h0);
        rd(4'd1, 128'h62636363626363636263636362636363);
        rd(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        rd_end();

        // Reset at E5, then a full A.1 expansion
        start_pulse(KA);
        repeat (5) @(posedge clk);
        #2; reset = 1'b1;
        #1;
        chk("abort_busy", {127'h0, busy}, 128'd0);
        chk("abort_kv", {127'h0, keys_valid}, 128'd0);
        #1; reset = 1'b0;
        start_pulse(KA);
        watch("restart");
        rd(4'd10, rka[10]);
        rd(4'd5, rka[5]);
        rd_end();

        chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1);
    end
endmodule
